ccr_branch_unit: RTL and testbench
==================================

// Module: ccr_branch_unit
// PURPOSE
//  Flag-consuming end of the ALU flag interface: holds the condition-code register (CCR).
//  Each cycle it captures {V,Z,N,C} from the ALU and resolves conditional jumps against the stored CCR.
//  It issues a registered redirect with a multi-cycle pipeline flush.
//  It saves and restores the CCR on interrupt entry and return (RTI) through a small LIFO.
// PARAMETERS
//  STACK_DEPTH  4   CCR save-stack entries (power of 2, >=2)
//  FLUSH_CYC    2   cycles br_flush is held after a taken branch (>=1)
//  ADDR_W       16  branch target / PC width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  flags_in      in   4       {V,Z,N,C} from the ALU, same order as the ALU flag outputs
//  flags_we      in   1       load flags_in into the CCR at the clock edge
//  br_valid      in   1       branch instruction present this cycle
//  br_type       in   2       00 JZ, 01 JN, 10 JC, 11 JMP
//  br_target     in   ADDR_W  branch destination
//  int_save      in   1       interrupt entry: push CCR
//  int_restore   in   1       RTI: pop top of stack into CCR
//  ccr_out       out  4       current CCR {V,Z,N,C}
//  br_taken      out  1       1-cycle pulse: redirect PC
//  pc_target     out  ADDR_W  valid while br_taken=1
//  br_flush      out  1       squash younger pipeline stages
//  stack_cnt     out  clog2(STACK_DEPTH)+1  occupied entries
//  ovf_err       out  1       sticky: push while full
//  unf_err       out  1       sticky: pop while empty
// BEHAVIOUR
//  Reset (async): ccr_out=0, br_taken=0, pc_target=0, br_flush=0, stack_cnt=0, ovf_err=0, unf_err=0, FSM=IDLE.
//  CCR update priority per edge:
//   1. int_restore with stack non-empty: CCR <= top; pop.
//   2. Otherwise, flags_we: CCR <= flags_in.
//   3. Otherwise: hold.
//  int_save pushes the pre-edge CCR, so a same-cycle flags_we lands in the CCR, not the stack.
//  Save and restore in the same cycle: restore wins, the save is dropped, no error raised.
//  Push when stack_cnt==STACK_DEPTH: no push, ovf_err<=1.
//  Pop when stack_cnt==0: CCR is still allowed to take flags_we, unf_err<=1.
//  Errors clear only on rst.
//  Branch condition uses the registered CCR as it was before the edge, never flags_in:
//   JZ=Z, JN=N, JC=C, JMP=1. Flag clearing on a taken jump is done by the ALU via flags_in.
//  FSM IDLE:
//   br_valid and condition true -> next cycle br_taken=1, pc_target=br_target, br_flush=1,
//   counter<=FLUSH_CYC-1, go FLUSH.
//   Condition false -> outputs stay 0.
//  FSM FLUSH:
//   br_taken=0, br_flush=1; br_valid is ignored (the wrong-path branch is squashed).
//   Counter decrements; at 0, br_flush drops next cycle and the FSM returns to IDLE.
//   FLUSH_CYC=1 means br_flush is high only in the br_taken cycle.
//  Flags and stack ops keep working during FLUSH.
//   The pipeline squashes flags_we itself; this unit does not gate it.
//  Latency: branch resolve 1 cycle. CCR visible on ccr_out 1 cycle after flags_we.
//  Reset mid-flush or mid-stack-op: everything returns to reset values immediately; stack contents are don't-care.
// STRUCTURE
//  defines.v gains: BR_JZ/BR_JN/BR_JC/BR_JMP codes, FLAG_V/Z/N/C bit indices.
//  Sub-module ccr_stack: LIFO with push, pop, top, cnt, full, empty.
//  Top level: CCR mux, condition mux, IDLE/FLUSH FSM + counter.
// TESTING
//  Reset and flags: rst=1 -> all outputs 0; flags_in=4'b0100, flags_we=1 -> ccr_out=4'b0100 next cycle.
//  Branch: CCR Z=1, br_valid, JZ, target 16'h0040 -> br_taken pulse 1 cycle, pc_target=0040,
//   br_flush high 2 cycles. Repeat with Z=0 -> no pulse.
//  Squash: a JMP arrives during FLUSH -> ignored, no second br_taken.
//   Same-cycle flags_we Z=1 with JZ on CCR Z=0 -> not taken.
//  Stack: push 1,2,3,4 (cnt=4), 5th push -> ovf_err=1, cnt=4.
//   Then 4 restores -> CCR sequence 4,3,2,1. 5th restore -> unf_err=1, CCR=1.
//  Conflicts: save+restore same cycle -> CCR=top, cnt-1.
//   Save with flags_we=4'b1000 while CCR=4'b0001 -> stack top=0001, CCR=1000.
//  Async reset during FLUSH with cnt=2 -> br_flush=0, cnt=0 before the next edge; errors cleared.

Source files
------------

// File: rtl/ccr_branch_unit_pkg.sv
// Shared types and constants for the condition-code / branch unit.
package ccr_branch_unit_pkg;

    // Branch type codes as presented on br_type
    typedef enum logic [1:0] {
        BR_JZ  = 2'b00,
        BR_JN  = 2'b01,
        BR_JC  = 2'b10,
        BR_JMP = 2'b11
    } br_type_e;

    // Bit positions inside the {V,Z,N,C} flag vector
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 3;

    // Redirect FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Resolve a branch condition against a stored CCR value
    function automatic logic branch_cond(input logic [3:0] ccr, input br_type_e t);
        logic c;
        case (t)
            BR_JZ:   c = ccr[FLAG_Z];
            BR_JN:   c = ccr[FLAG_N];
            BR_JC:   c = ccr[FLAG_C];
            default: c = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ccr_branch_unit_if.sv
// Flag / branch / CCR-stack signal bundle between pipeline and the branch unit.
interface ccr_branch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 3
);
    logic [3:0]        flags_in;
    logic              flags_we;
    logic              br_valid;
    logic [1:0]        br_type;
    logic [ADDR_W-1:0] br_target;
    logic              int_save;
    logic              int_restore;
    logic [3:0]        ccr_out;
    logic              br_taken;
    logic [ADDR_W-1:0] pc_target;
    logic              br_flush;
    logic [CNT_W-1:0]  stack_cnt;
    logic              ovf_err;
    logic              unf_err;

    // Branch unit side
    modport slave (
        input  flags_in, flags_we, br_valid, br_type, br_target, int_save, int_restore,
        output ccr_out, br_taken, pc_target, br_flush, stack_cnt, ovf_err, unf_err
    );

    // Pipeline / driver side
    modport master (
        output flags_in, flags_we, br_valid, br_type, br_target, int_save, int_restore,
        input  ccr_out, br_taken, pc_target, br_flush, stack_cnt, ovf_err, unf_err
    );
endinterface

// File: rtl/ccr_branch_unit_stack.sv
// Small LIFO holding saved CCR values across interrupt nesting.
// Push and pop requests are ignored when full / empty respectively.
module ccr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               top_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && !full_o && !pop_i;
    assign top_o   = mem_q[PTR_W'(cnt_q - CNT_W'(1))];
    assign cnt_o   = cnt_q;

    // Occupancy counter; pop takes precedence over push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop_en) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (push_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Storage is not reset; contents beyond cnt_q are don't-care
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[PTR_W'(cnt_q)] <= data_i;
        end
    end

endmodule

// File: rtl/ccr_branch_unit.sv
// Condition-code register with branch resolution, redirect/flush FSM and
// interrupt save/restore of the CCR through a LIFO.
module ccr_branch_unit
    import ccr_branch_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int FLUSH_CYC   = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    ccr_branch_unit_if.slave  bus
);
    localparam int SCNT_W = $clog2(STACK_DEPTH) + 1;
    localparam int FC_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e            state_q, state_d;
    logic [3:0]        ccr_q, ccr_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [3:0]        stk_top;
    logic [SCNT_W-1:0] stk_cnt;
    logic              stk_full;
    logic              stk_empty;
    logic              cond;

    ccr_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (4)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.int_save),
        .pop_i   (bus.int_restore),
        .data_i  (ccr_q),
        .top_o   (stk_top),
        .cnt_o   (stk_cnt),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign cond = branch_cond(ccr_q, br_type_e'(bus.br_type));

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ccr_q   <= '0;
            taken_q <= 1'b0;
            pc_q    <= '0;
            flush_q <= 1'b0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ccr_q   <= ccr_d;
            taken_q <= taken_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // CCR source selection, sticky stack errors, redirect FSM
    always_comb begin
        ccr_d   = ccr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        state_d = state_q;
        taken_d = 1'b0;
        pc_d    = '0;
        flush_d = 1'b0;
        fcnt_d  = fcnt_q;

        // A restore masks any same-cycle save, so overflow is only flagged for a lone save
        if (bus.int_restore && !stk_empty) begin
            ccr_d = stk_top;
        end else if (bus.flags_we) begin
            ccr_d = bus.flags_in;
        end
        if (bus.int_restore && stk_empty) begin
            unf_d = 1'b1;
        end
        if (bus.int_save && !bus.int_restore && stk_full) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.br_valid && cond) begin
                    taken_d = 1'b1;
                    pc_d    = bus.br_target;
                    flush_d = 1'b1;
                    fcnt_d  = FC_W'(FLUSH_CYC - 1);
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d  = fcnt_q - FC_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ccr_out   = ccr_q;
    assign bus.br_taken  = taken_q;
    assign bus.pc_target = pc_q;
    assign bus.br_flush  = flush_q;
    assign bus.stack_cnt = stk_cnt;
    assign bus.ovf_err   = ovf_q;
    assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Scoreboard bench: each driven cycle queues the outputs expected after the
// next rising edge; an independent monitor pops and compares after each edge.
module tb_ccr_branch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int          id;
        logic [3:0]  ccr;
        logic        tk;
        logic [15:0] pc;
        logic        fl;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sbq[$];

    ccr_branch_unit_if #(.ADDR_W(16), .CNT_W(3)) bus ();

    ccr_branch_unit #(
        .STACK_DEPTH (4),
        .FLUSH_CYC   (2),
        .ADDR_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic step(input int id,
                        input logic [3:0] fin, input logic fwe,
                        input logic bv, input logic [1:0] bt, input logic [15:0] tgt,
                        input logic sv, input logic rs,
                        input logic [3:0] e_ccr, input logic e_tk, input logic [15:0] e_pc,
                        input logic e_fl, input logic [2:0] e_cnt, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        bus.flags_in    = fin;
        bus.flags_we    = fwe;
        bus.br_valid    = bv;
        bus.br_type     = bt;
        bus.br_target   = tgt;
        bus.int_save    = sv;
        bus.int_restore = rs;
        e.id = id; e.ccr = e_ccr; e.tk = e_tk; e.pc = e_pc; e.fl = e_fl;
        e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        sbq.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.flags_in = '0; bus.flags_we = 1'b0; bus.br_valid = 1'b0; bus.br_type = '0;
        bus.br_target = '0; bus.int_save = 1'b0; bus.int_restore = 1'b0;
    endtask

    // Monitor: compares every registered output once per edge against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ccr",   e.id, 32'(bus.ccr_out),   32'(e.ccr));
                chk("taken", e.id, 32'(bus.br_taken),  32'(e.tk));
                chk("pc",    e.id, 32'(bus.pc_target), 32'(e.pc));
                chk("flush", e.id, 32'(bus.br_flush),  32'(e.fl));
                chk("cnt",   e.id, 32'(bus.stack_cnt), 32'(e.cnt));
                chk("ovf",   e.id, 32'(bus.ovf_err),   32'(e.ovf));
                chk("unf",   e.id, 32'(bus.unf_err),   32'(e.unf));
            end
        end
    end

    task automatic chk_all_zero(input int id);
        chk("rst_ccr",   id, 32'(bus.ccr_out),   32'h0);
        chk("rst_taken", id, 32'(bus.br_taken),  32'h0);
        chk("rst_pc",    id, 32'(bus.pc_target), 32'h0);
        chk("rst_flush", id, 32'(bus.br_flush),  32'h0);
        chk("rst_cnt",   id, 32'(bus.stack_cnt), 32'h0);
        chk("rst_ovf",   id, 32'(bus.ovf_err),   32'h0);
        chk("rst_unf",   id, 32'(bus.unf_err),   32'h0);
    endtask

    initial begin
        idle_inputs();
        #2;
        chk_all_zero(0);
        @(negedge clk);
        rst = 1'b0;

        //    id  fin    we  bv  bt     tgt       sv  rs   ccr    tk  pc        fl  cnt ovf unf
        // flags load and JZ taken with a 2-cycle flush
        step( 1, 4'b0100, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b0100, 0, 16'h0000, 0, 0, 0, 0);
        step( 2, 4'b0000, 0, 1, 2'b00, 16'h0040, 0, 0,  4'b0100, 1, 16'h0040, 1, 0, 0, 0);
        step( 3, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0100, 0, 16'h0000, 1, 0, 0, 0);
        step( 4, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0100, 0, 16'h0000, 0, 0, 0, 0);
        step( 5, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0100, 0, 16'h0000, 0, 0, 0, 0);
        // JZ with Z=0: no redirect
        step( 6, 4'b0000, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        step( 7, 4'b0000, 0, 1, 2'b00, 16'h0040, 0, 0,  4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        // JMP, then a JMP during FLUSH is squashed
        step( 8, 4'b0000, 0, 1, 2'b11, 16'h1234, 0, 0,  4'b0000, 1, 16'h1234, 1, 0, 0, 0);
        step( 9, 4'b0000, 0, 1, 2'b11, 16'h5678, 0, 0,  4'b0000, 0, 16'h0000, 1, 0, 0, 0);
        step(10, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        // same-cycle flags Z=1 does not affect JZ on old CCR
        step(11, 4'b0100, 1, 1, 2'b00, 16'h0040, 0, 0,  4'b0100, 0, 16'h0000, 0, 0, 0, 0);
        step(12, 4'b0000, 0, 1, 2'b01, 16'h0050, 0, 0,  4'b0100, 0, 16'h0000, 0, 0, 0, 0);
        step(13, 4'b0011, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b0011, 0, 16'h0000, 0, 0, 0, 0);
        step(14, 4'b0000, 0, 1, 2'b10, 16'h00AA, 0, 0,  4'b0011, 1, 16'h00AA, 1, 0, 0, 0);
        step(15, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0011, 0, 16'h0000, 1, 0, 0, 0);
        step(16, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0011, 0, 16'h0000, 0, 0, 0, 0);
        // push 1,2,3,4 (save takes pre-edge CCR while flags_we loads the next value)
        step(17, 4'b0001, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b0001, 0, 16'h0000, 0, 0, 0, 0);
        step(18, 4'b0010, 1, 0, 2'b00, 16'h0000, 1, 0,  4'b0010, 0, 16'h0000, 0, 1, 0, 0);
        step(19, 4'b0011, 1, 0, 2'b00, 16'h0000, 1, 0,  4'b0011, 0, 16'h0000, 0, 2, 0, 0);
        step(20, 4'b0100, 1, 0, 2'b00, 16'h0000, 1, 0,  4'b0100, 0, 16'h0000, 0, 3, 0, 0);
        step(21, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 0,  4'b0100, 0, 16'h0000, 0, 4, 0, 0);
        step(22, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 0,  4'b0100, 0, 16'h0000, 0, 4, 1, 0);
        // pop 4,3,2,1 then underflow
        step(23, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 1,  4'b0100, 0, 16'h0000, 0, 3, 1, 0);
        step(24, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 1,  4'b0011, 0, 16'h0000, 0, 2, 1, 0);
        step(25, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 1,  4'b0010, 0, 16'h0000, 0, 1, 1, 0);
        step(26, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 1,  4'b0001, 0, 16'h0000, 0, 0, 1, 0);
        step(27, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 1,  4'b0001, 0, 16'h0000, 0, 0, 1, 1);
        step(28, 4'b0110, 1, 0, 2'b00, 16'h0000, 0, 1,  4'b0110, 0, 16'h0000, 0, 0, 1, 1);
        // save+restore same cycle: restore wins
        step(29, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 0,  4'b0110, 0, 16'h0000, 0, 1, 1, 1);
        step(30, 4'b1111, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b1111, 0, 16'h0000, 0, 1, 1, 1);
        step(31, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 1,  4'b0110, 0, 16'h0000, 0, 0, 1, 1);
        // save with flags_we: stack gets old CCR; restore beats flags_we
        step(32, 4'b0001, 1, 0, 2'b00, 16'h0000, 0, 0,  4'b0001, 0, 16'h0000, 0, 0, 1, 1);
        step(33, 4'b1000, 1, 0, 2'b00, 16'h0000, 1, 0,  4'b1000, 0, 16'h0000, 0, 1, 1, 1);
        step(34, 4'b1111, 1, 0, 2'b00, 16'h0000, 0, 1,  4'b0001, 0, 16'h0000, 0, 0, 1, 1);
        // enter FLUSH with two entries stacked
        step(35, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 0,  4'b0001, 0, 16'h0000, 0, 1, 1, 1);
        step(36, 4'b0000, 0, 0, 2'b00, 16'h0000, 1, 0,  4'b0001, 0, 16'h0000, 0, 2, 1, 1);
        step(37, 4'b0000, 0, 1, 2'b11, 16'h0BEE, 0, 0,  4'b0001, 1, 16'h0BEE, 1, 2, 1, 1);
        step(38, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0001, 0, 16'h0000, 1, 2, 1, 1);

        // asynchronous reset mid-flush: outputs clear before any edge
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_all_zero(39);
        @(negedge clk);
        rst = 1'b0;
        step(40, 4'b0000, 0, 0, 2'b00, 16'h0000, 0, 0,  4'b0000, 0, 16'h0000, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
